// File: rtl/ysyx_22050612_wbu.sv
// Writeback unit: arbitrates ALU results and load responses onto the single
// register-file write port, extracts load data, and counts retired operations.
module ysyx_22050612_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [63:0]           lsu_rdata,
    input  logic [2:0]            lsu_funct3,
    input  logic [2:0]            lsu_offset,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  load_err,
    output logic [63:0]           retired
);

    logic [1:0]            starve_cnt;
    logic                  starved;
    logic                  alu_acc;
    logic                  lsu_acc;
    logic                  load_illegal;
    logic [63:0]           shifted;
    logic [63:0]           load_data;
    logic                  do_write;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    assign starved = (starve_cnt == 2'd3);

    // LSU normally wins a conflict; the ALU gets one turn after three straight losses.
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst) begin
            alu_ready = alu_valid && (!lsu_valid || starved);
            lsu_ready = lsu_valid && !(alu_valid && starved);
        end
    end

    assign alu_acc      = alu_valid && alu_ready;
    assign lsu_acc      = lsu_valid && lsu_ready;
    assign load_illegal = (lsu_funct3 == 3'b111);
    assign shifted      = lsu_rdata >> {lsu_offset, 3'b000};

    always_comb begin
        load_data = 64'd0;
        case (lsu_funct3)
            3'b000:  load_data = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  load_data = shifted;
            3'b100:  load_data = {56'd0, shifted[7:0]};
            3'b101:  load_data = {48'd0, shifted[15:0]};
            3'b110:  load_data = {32'd0, shifted[31:0]};
            default: load_data = 64'd0;
        endcase
    end

    always_comb begin
        sel_rd   = alu_rd;
        sel_data = alu_data;
        do_write = 1'b0;
        if (alu_acc) begin
            do_write = (alu_rd != '0);
        end else if (lsu_acc) begin
            sel_rd   = lsu_rd;
            sel_data = load_data;
            do_write = !load_illegal && (lsu_rd != '0);
        end
    end

    // waddr/wdata only move on a real write so they keep the last written value.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen        <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            load_err   <= 1'b0;
            retired    <= 64'd0;
            starve_cnt <= 2'd0;
        end else begin
            wen      <= do_write;
            load_err <= lsu_acc && load_illegal;
            if (do_write) begin
                waddr <= sel_rd;
                wdata <= sel_data;
            end
            if (alu_acc || lsu_acc) begin
                retired <= retired + 64'd1;
            end
            if (alu_valid && !alu_acc) begin
                starve_cnt <= starved ? 2'd3 : starve_cnt + 2'd1;
            end else begin
                starve_cnt <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_wbu.sv
// Self-checking bench for the writeback unit: directed vector table, hand-written
// arbitration/reset sequences, and randomized traffic against a behavioural model.
module tb_ysyx_22050612_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_rdata;
    logic [2:0]  lsu_funct3;
    logic [2:0]  lsu_offset;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        load_err;
    logic [63:0] retired;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit              m_wen;
    logic [4:0]      m_waddr;
    longint unsigned m_wdata;
    bit              m_err;
    longint unsigned m_retired;
    int              m_starve;

    bit got_ar;
    bit got_lr;

    typedef struct {
        bit          av;
        logic [4:0]  ard;
        logic [63:0] adata;
        bit          lv;
        logic [4:0]  lrd;
        logic [63:0] lrdata;
        logic [2:0]  f3;
        logic [2:0]  off;
        bit          e_ar;
        bit          e_lr;
        bit          e_wen;
        logic [4:0]  e_waddr;
        logic [63:0] e_wdata;
        bit          e_err;
        logic [63:0] e_ret;
    } vec_t;

    vec_t vecs[12];

    ysyx_22050612_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_rdata  (lsu_rdata),
        .lsu_funct3 (lsu_funct3),
        .lsu_offset (lsu_offset),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .load_err   (load_err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Load extraction written as arithmetic on the shifted doubleword.
    function automatic longint unsigned model_load(longint unsigned rdata, int f3, int off);
        longint unsigned s;
        longint unsigned v;
        s = rdata >> (8 * off);
        case (f3)
            0: begin v = s % 256;   if (v >= 128)   v = v - 256;   end
            1: begin v = s % 65536; if (v >= 32768) v = v - 65536; end
            2: begin
                v = s % 64'h1_0000_0000;
                if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
            end
            3: v = s;
            4: v = s % 256;
            5: v = s % 65536;
            6: v = s % 64'h1_0000_0000;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic applyStimulus(input bit r, input bit av, input logic [4:0] ard,
                                 input logic [63:0] ad, input bit lv, input logic [4:0] lrd,
                                 input logic [63:0] lrdata, input logic [2:0] f3,
                                 input logic [2:0] off);
        bit ear;
        bit elr;
        bit wr;
        logic [4:0] rd;
        longint unsigned val;
        @(negedge clk);
        rst        = r;
        alu_valid  = av;
        alu_rd     = ard;
        alu_data   = ad;
        lsu_valid  = lv;
        lsu_rd     = lrd;
        lsu_rdata  = lrdata;
        lsu_funct3 = f3;
        lsu_offset = off;
        #1;
        ear = 0;
        elr = 0;
        if (!r) begin
            if (av && lv) begin
                if (m_starve == 3) ear = 1;
                else elr = 1;
            end else begin
                ear = av;
                elr = lv;
            end
        end
        got_ar = alu_ready;
        got_lr = lsu_ready;
        check("alu_ready", {63'd0, alu_ready}, {63'd0, ear});
        check("lsu_ready", {63'd0, lsu_ready}, {63'd0, elr});
        @(posedge clk);
        if (r) begin
            m_wen = 0; m_waddr = 0; m_wdata = 0; m_err = 0; m_retired = 0; m_starve = 0;
        end else begin
            wr = 0;
            rd = 0;
            val = 0;
            if (ear) begin
                rd = ard; val = ad; wr = (ard != 0);
            end else if (elr) begin
                rd = lrd; val = model_load(lrdata, int'(f3), int'(off));
                wr = (f3 != 3'd7) && (lrd != 0);
            end
            m_wen = wr;
            if (wr) begin
                m_waddr = rd;
                m_wdata = val;
            end
            m_err = elr && (f3 == 3'd7);
            if (ear || elr) m_retired = m_retired + 1;
            if (av && !ear) m_starve = (m_starve < 3) ? m_starve + 1 : 3;
            else m_starve = 0;
        end
        #1;
    endtask

    task automatic checkOutput();
        check("wen",      {63'd0, wen},      {63'd0, m_wen});
        check("waddr",    {59'd0, waddr},    {59'd0, m_waddr});
        check("wdata",    wdata,             m_wdata);
        check("load_err", {63'd0, load_err}, {63'd0, m_err});
        check("retired",  retired,           m_retired);
    endtask

    function automatic vec_t mk(bit av, logic [4:0] ard, logic [63:0] ad, bit lv,
                                logic [4:0] lrd, logic [63:0] lrdata, logic [2:0] f3,
                                logic [2:0] off, bit e_wen, logic [4:0] e_waddr,
                                logic [63:0] e_wdata, bit e_err, logic [63:0] e_ret);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = ad;
        v.lv = lv; v.lrd = lrd; v.lrdata = lrdata; v.f3 = f3; v.off = off;
        v.e_ar = av; v.e_lr = lv;
        v.e_wen = e_wen; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
        v.e_err = e_err; v.e_ret = e_ret;
        return v;
    endfunction

    initial begin
        bit exp_ar[5];
        bit exp_lr[5];

        vecs[0]  = mk(1, 5, 64'h1234, 0, 0, 0, 0, 0,                               1, 5, 64'h1234, 0, 1);
        vecs[1]  = mk(0, 0, 0, 1, 7, 64'h0000_0000_0080_0000, 3'b000, 3'd2,        1, 7, 64'hFFFF_FFFF_FFFF_FF80, 0, 2);
        vecs[2]  = mk(0, 0, 0, 1, 7, 64'h0000_0000_0080_0000, 3'b100, 3'd2,        1, 7, 64'h80, 0, 3);
        vecs[3]  = mk(1, 0, 64'hFFFF, 0, 0, 0, 0, 0,                               0, 7, 64'h80, 0, 4);
        vecs[4]  = mk(0, 0, 0, 1, 9, 64'h1234_5678, 3'b111, 3'd0,                  0, 7, 64'h80, 1, 5);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                                      0, 7, 64'h80, 0, 5);
        vecs[6]  = mk(0, 0, 0, 1, 3, 64'h0000_0000_8001_0000, 3'b001, 3'd2,        1, 3, 64'hFFFF_FFFF_FFFF_8001, 0, 6);
        vecs[7]  = mk(0, 0, 0, 1, 4, 64'h8765_4321_0000_0000, 3'b010, 3'd4,        1, 4, 64'hFFFF_FFFF_8765_4321, 0, 7);
        vecs[8]  = mk(0, 0, 0, 1, 4, 64'h8765_4321_0000_0000, 3'b110, 3'd4,        1, 4, 64'h0000_0000_8765_4321, 0, 8);
        vecs[9]  = mk(0, 0, 0, 1, 10, 64'hDEAD_BEEF_CAFE_F00D, 3'b011, 3'd0,       1, 10, 64'hDEAD_BEEF_CAFE_F00D, 0, 9);
        vecs[10] = mk(0, 0, 0, 1, 11, 64'hF234_0000_0000_0000, 3'b101, 3'd6,       1, 11, 64'hF234, 0, 10);
        vecs[11] = mk(0, 0, 0, 1, 12, 64'h1122_3344_5566_7788, 3'b011, 3'd3,       1, 12, 64'h0000_0011_2233_4455, 0, 11);

        rst = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_rdata = 0; lsu_funct3 = 0; lsu_offset = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_wen",     {63'd0, wen}, 64'd0);
        check("reset_wdata",   wdata, 64'd0);
        check("reset_retired", retired, 64'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].lv, vecs[i].lrd,
                          vecs[i].lrdata, vecs[i].f3, vecs[i].off);
            check($sformatf("vec%0d_alu_ready", i), {63'd0, got_ar}, {63'd0, vecs[i].e_ar});
            check($sformatf("vec%0d_lsu_ready", i), {63'd0, got_lr}, {63'd0, vecs[i].e_lr});
            check($sformatf("vec%0d_wen", i),      {63'd0, wen},      {63'd0, vecs[i].e_wen});
            check($sformatf("vec%0d_waddr", i),    {59'd0, waddr},    {59'd0, vecs[i].e_waddr});
            check($sformatf("vec%0d_wdata", i),    wdata,             vecs[i].e_wdata);
            check($sformatf("vec%0d_load_err", i), {63'd0, load_err}, {63'd0, vecs[i].e_err});
            check($sformatf("vec%0d_retired", i),  retired,           vecs[i].e_ret);
            checkOutput();
        end

        // Five-cycle conflict: LSU, LSU, LSU, ALU, LSU
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_ar = '{0, 0, 0, 1, 0};
        exp_lr = '{1, 1, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 1, 64'h100 + 64'(i), 1, 2, 64'h200 + 64'(i), 3'b011, 3'd0);
            check($sformatf("conflict%0d_alu_ready", i), {63'd0, got_ar}, {63'd0, exp_ar[i]});
            check($sformatf("conflict%0d_lsu_ready", i), {63'd0, got_lr}, {63'd0, exp_lr[i]});
            check($sformatf("conflict%0d_waddr", i), {59'd0, waddr}, exp_ar[i] ? 64'd1 : 64'd2);
            checkOutput();
        end

        // Reset with both sources valid, then first grant after release goes to LSU
        applyStimulus(1, 1, 6, 64'h66, 1, 8, 64'h88, 3'b011, 3'd0);
        check("rst_alu_ready", {63'd0, got_ar}, 64'd0);
        check("rst_lsu_ready", {63'd0, got_lr}, 64'd0);
        check("rst_wen",       {63'd0, wen}, 64'd0);
        check("rst_waddr",     {59'd0, waddr}, 64'd0);
        check("rst_retired",   retired, 64'd0);
        applyStimulus(0, 1, 6, 64'h66, 1, 8, 64'h88, 3'b011, 3'd0);
        check("post_rst_lsu_ready", {63'd0, got_lr}, 64'd1);
        check("post_rst_waddr",     {59'd0, waddr}, 64'd8);
        checkOutput();

        // Op accepted just before reset is written; reset then clears everything
        applyStimulus(0, 1, 13, 64'hABCD, 0, 0, 0, 0, 0);
        check("pre_rst_wen",   {63'd0, wen}, 64'd1);
        check("pre_rst_wdata", wdata, 64'hABCD);
        applyStimulus(1, 1, 13, 64'hABCD, 0, 0, 0, 0, 0);
        check("after_rst_wen",     {63'd0, wen}, 64'd0);
        check("after_rst_retired", retired, 64'd0);
        checkOutput();

        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)));
            checkOutput();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_wbu.md
YSYX_22050612_WBU -- requirements
Module: ysyx_22050612_WBU

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, register data width (fixed 64 in this revision).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port alu_valid  input  1  ALU result offered.
REQ-006 SHALL have port alu_ready  output  1  ALU result accepted this cycle when high with alu_valid.
REQ-007 SHALL have port alu_rd  input  ADDR_WIDTH  ALU destination register.
REQ-008 SHALL have port alu_data  input  DATA_WIDTH  ALU result.
REQ-009 SHALL have port lsu_valid  input  1  load response offered.
REQ-010 SHALL have port lsu_ready  output  1  load response accepted when high with lsu_valid.
REQ-011 SHALL have port lsu_rd  input  ADDR_WIDTH  load destination register.
REQ-012 SHALL have port lsu_rdata  input  64  raw aligned doubleword from memory.
REQ-013 SHALL have port lsu_funct3  input  3  load type (RISC-V funct3).
REQ-014 SHALL have port lsu_offset  input  3  byte offset of access within doubleword.
REQ-015 SHALL have ports wen output 1, waddr output ADDR_WIDTH, wdata output DATA_WIDTH, driving the register-file write port directly.
REQ-016 SHALL have port load_err  output  1  one-cycle pulse on an illegal load type.
REQ-017 SHALL have port retired  output  64  count of accepted writeback operations.

Function
REQ-018 Accept: a source is accepted in cycle N when its valid and ready are both high at posedge N.
REQ-019 Latency: an accepted op drives wen/waddr/wdata from posedge N for exactly one cycle (registered output); with no accept, wen=0 next cycle.
REQ-020 Throughput: at most one op accepted per cycle; with no conflict, the sole valid source has ready=1 every cycle.
REQ-021 Arbitration: if both valid, LSU wins (lsu_ready=1, alu_ready=0), unless starve_cnt==3, in which case ALU wins (alu_ready=1, lsu_ready=0).
REQ-022 starve_cnt (2 bits): increments when alu_valid=1 and ALU loses; clears when ALU accepted or alu_valid=0; saturates at 3.
REQ-023 ready outputs are combinational from valids and starve_cnt; they do not depend on ready inputs.
REQ-024 Load extract: shift lsu_rdata right by 8*lsu_offset, then funct3 000 LB sign-ext bits 7:0, 001 LH 15:0 sign, 010 LW 31:0 sign, 011 LD full 64, 100 LBU zero, 101 LHU zero, 110 LWU zero.
REQ-025 Misalignment is not checked; the shifted value is used as-is (upper bits zero-filled by shift).
REQ-026 funct3 111: response accepted, no write (wen=0), load_err=1 for one cycle from posedge N, retired incremented.
REQ-027 rd==0: op accepted and retired incremented, but wen=0 next cycle (x0 never written).
REQ-028 waddr/wdata hold last written value when wen=0.
REQ-029 retired increments by 1 per accepted op, wraps 2^64-1 to 0.

Reset
REQ-030 While rst=1 at posedge: wen=0, waddr=0, wdata=0, load_err=0, retired=0, starve_cnt=0.
REQ-031 During rst=1, alu_ready=lsu_ready=0; no op accepted; an op offered in the reset cycle is dropped (source must hold).
REQ-032 An op accepted in the cycle before rst asserts is written (wen=1 that cycle); nothing after.

Verification
REQ-033 ALU only: alu_valid=1, rd=5, data=0x1234 -> next cycle wen=1, waddr=5, wdata=0x1234, retired=1.
REQ-034 LB sign: lsu_rdata=0x0000_0000_0080_0000, offset=2, funct3=000, rd=7 -> wdata=0xFFFF_FFFF_FFFF_FF80; funct3=100 -> 0x80.
REQ-035 Conflict: both valid 5 cycles straight -> grants LSU,LSU,LSU,ALU,LSU; starve_cnt back to 0 after ALU grant.
REQ-036 rd=0 via ALU, data=0xFFFF -> wen=0, retired increments.
REQ-037 funct3=111 -> load_err pulse 1 cycle, wen=0, lsu_ready=1.
REQ-038 rst asserted with both valid -> both ready=0, outputs zero; after release first grant goes to LSU.
